// File: rtl/fft32_mdc_ctrl.sv
// Sequencing controller for the 32-point radix-2 MDC FFT: tracks accepted
// input pairs through a fixed-latency valid pipeline and derives per-stage
// commutator selects, twiddle indices and output framing.
module fft32_mdc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_first,
  output logic       sw1,
  output logic       sw2,
  output logic       sw3,
  output logic       sw4,
  output logic [3:0] tw32_idx,
  output logic [2:0] tw16_idx,
  output logic [1:0] tw8_idx,
  output logic       tw4_idx,
  output logic       out_valid,
  output logic       out_last,
  output logic       frame_err
);

  localparam int unsigned LAT = 20;
  localparam int unsigned O2  = 9;
  localparam int unsigned O3  = 14;
  localparam int unsigned O4  = 17;

  logic [3:0]     in_cnt;
  logic [3:0]     cnt_2;
  logic [3:0]     cnt_3;
  logic [3:0]     cnt_4;
  logic [3:0]     ocnt;
  logic [LAT:1]   vsr_q;
  logic [LAT:0]   vsr;
  logic           acc;

  // A started frame is always taken to completion, even if in_valid drops.
  assign acc = in_valid | (in_cnt != '0);
  assign vsr = {vsr_q, acc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt    <= '0;
      cnt_2     <= '0;
      cnt_3     <= '0;
      cnt_4     <= '0;
      ocnt      <= '0;
      vsr_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      vsr_q <= vsr[LAT-1:0];
      if (acc)       in_cnt <= in_cnt + 4'd1;
      if (vsr[O2])   cnt_2  <= cnt_2 + 4'd1;
      if (vsr[O3])   cnt_3  <= cnt_3 + 4'd1;
      if (vsr[O4])   cnt_4  <= cnt_4 + 4'd1;
      if (out_valid) ocnt   <= ocnt + 4'd1;
      if ((in_cnt != '0) && !in_valid) frame_err <= 1'b1;
    end
  end

  // Stage-1 counter is the input counter itself.
  assign in_first  = acc & (in_cnt == '0);
  assign sw1       = in_cnt[3];
  assign sw2       = cnt_2[2];
  assign sw3       = cnt_3[1];
  assign sw4       = cnt_4[0];
  assign tw32_idx  = in_cnt;
  assign tw16_idx  = cnt_2[2:0];
  assign tw8_idx   = cnt_3[1:0];
  assign tw4_idx   = cnt_4[0];
  assign out_valid = vsr[LAT];
  assign out_last  = out_valid & (ocnt == 4'd15);

endmodule
